// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared opcodes, states and status bit indices for the SPI flash responder
//
// Purpose: definitions shared by spi_flash_responder and spi_target_shifter.
// Ports: none (package).
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'h20;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_WRDI = 8'h04;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  // Status register bit positions
  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RDID,
    ST_RDSR,
    ST_READ,
    ST_PROG,
    ST_ERASE_WAIT,
    ST_IGNORE
  } state_t;

  // What the collected address will be used for
  typedef enum logic [1:0] {
    KIND_READ,
    KIND_PROG,
    KIND_ERASE
  } addr_kind_t;

  // WEL change requested by WREN/WRDI, applied when CS rises
  typedef enum logic [1:0] {
    WEL_KEEP,
    WEL_SET,
    WEL_CLR
  } wel_op_t;

endpackage

// File: rtl/spi_target_shifter.sv
// rtl/spi_target_shifter.sv - oversampled SPI mode-0 target bit engine
//
// Purpose: synchronizes the SPI pins into i_clk, detects CS/SCLK edges,
// assembles received bytes and shifts response bytes out MSB first.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_spi_csel/clk/mosi     raw SPI pins
//   i_tx_byte               response byte, sampled on o_load
//   o_spi_miso              target-out data
//   o_cs_active             synchronized chip select asserted
//   o_cs_fall, o_cs_rise    chip select edges (one cycle)
//   o_sclk_rise             qualified SCLK rise
//   o_byte_done             SCLK rise that completes a byte
//   o_rx_byte               received byte, valid with o_byte_done
//   o_load                  SCLK fall at a byte boundary (i_tx_byte taken)
module spi_target_shifter (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_spi_csel,
  input  logic       i_spi_clk,
  input  logic       i_spi_mosi,
  input  logic [7:0] i_tx_byte,
  output logic       o_spi_miso,
  output logic       o_cs_active,
  output logic       o_cs_fall,
  output logic       o_cs_rise,
  output logic       o_sclk_rise,
  output logic       o_byte_done,
  output logic [7:0] o_rx_byte,
  output logic       o_load
);

  logic [1:0] r_csel_sync;
  logic [1:0] r_sclk_sync;
  logic [1:0] r_mosi_sync;
  logic       r_csel_d;
  logic       r_sclk_d;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_sr;
  logic [7:0] r_tx_sr;
  logic       r_miso;

  logic       w_cs_active;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic [7:0] w_rx_byte;

  // SCLK edges only count while CS is held low; a CS rise therefore masks
  // any SCLK edge landing in the same cycle.
  assign w_cs_active = ~r_csel_sync[1];
  assign w_sclk_rise = w_cs_active & r_sclk_sync[1] & ~r_sclk_d;
  assign w_sclk_fall = w_cs_active & ~r_sclk_sync[1] & r_sclk_d;
  assign w_rx_byte   = {r_rx_sr, r_mosi_sync[1]};

  assign o_spi_miso  = r_miso;
  assign o_cs_active = w_cs_active;
  assign o_cs_fall   = r_csel_d & ~r_csel_sync[1];
  assign o_cs_rise   = ~r_csel_d & r_csel_sync[1];
  assign o_sclk_rise = w_sclk_rise;
  assign o_byte_done = w_sclk_rise & (r_bit_cnt == 3'd7);
  assign o_rx_byte   = w_rx_byte;
  assign o_load      = w_sclk_fall & (r_bit_cnt == 3'd0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // CS history resets to "selected" so a frame already in progress at
      // reset release produces no falling edge and is ignored until CS
      // has gone high once.
      r_csel_sync <= 2'b00;
      r_csel_d    <= 1'b0;
      r_sclk_sync <= 2'b00;
      r_sclk_d    <= 1'b0;
      r_mosi_sync <= 2'b00;
      r_bit_cnt   <= 3'd0;
      r_rx_sr     <= 7'd0;
      r_tx_sr     <= 8'd0;
      r_miso      <= 1'b0;
    end else begin
      r_csel_sync <= {r_csel_sync[0], i_spi_csel};
      r_csel_d    <= r_csel_sync[1];
      r_sclk_sync <= {r_sclk_sync[0], i_spi_clk};
      r_sclk_d    <= r_sclk_sync[1];
      r_mosi_sync <= {r_mosi_sync[0], i_spi_mosi};
      if (!w_cs_active) begin
        r_bit_cnt <= 3'd0;
        r_tx_sr   <= 8'd0;
        r_miso    <= 1'b0;
      end else begin
        if (w_sclk_rise) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_rx_sr   <= w_rx_byte[6:0];
        end
        if (w_sclk_fall) begin
          if (r_bit_cnt == 3'd0) begin
            r_miso  <= i_tx_byte[7];
            r_tx_sr <= {i_tx_byte[6:0], 1'b0};
          end else begin
            r_miso  <= r_tx_sr[7];
            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI NOR flash emulator fronting a byte-wide memory
//
// Purpose: decodes READ/PP/SE/RDSR/WREN/WRDI/RDID from an SPI mode-0 master
// and drives a byte-wide backing store; models WEL and a timed WIP.
// Ports:
//   i_clk_48mhz, i_reset    clock, synchronous active-high reset
//   i_spi_csel/clk/mosi     SPI inputs (CS active low, SCLK idle low)
//   o_spi_miso              SPI output
//   o_mem_addr              backing-store byte address
//   o_mem_re, i_mem_rdata   read strobe, data valid the following cycle
//   o_mem_we, o_mem_wdata   one-cycle write strobe and data
//   o_erase_req             one-cycle sector erase request at o_mem_addr
//   o_wip                   write-in-progress status bit
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W      = 24,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          BUSY_CYCLES = 4096,
  parameter int          PAGE_W      = 8
) (
  input  logic              i_clk_48mhz,
  input  logic              i_reset,
  input  logic              i_spi_csel,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata,
  output logic              o_erase_req,
  output logic              o_wip
);

  localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);

  state_t             r_state;
  addr_kind_t         r_kind;
  wel_op_t            r_wel_op;
  logic               r_wel;
  logic               r_wip;
  logic [BUSY_W-1:0]  r_busy_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [1:0]         r_addr_cnt;
  logic [1:0]         r_out_idx;
  logic               r_prog_wrote;
  logic [7:0]         r_rdata;
  logic               r_mem_re;
  logic               r_re_pend;
  logic               r_mem_we;
  logic [7:0]         r_wdata;
  logic               r_erase_req;

  state_t             w_state_next;
  addr_kind_t         w_kind_next;
  wel_op_t            w_wel_op_next;
  logic               w_re_set;
  logic               w_we_set;
  logic               w_erase_set;
  logic               w_busy_start;
  logic [7:0]         w_tx_byte;
  logic [7:0]         w_status;

  logic               w_cs_active;
  logic               w_cs_fall;
  logic               w_cs_rise;
  logic               w_sclk_rise;
  logic               w_byte_done;
  logic [7:0]         w_rx_byte;
  logic               w_load;

  spi_target_shifter u_shifter (
    .i_clk       (i_clk_48mhz),
    .i_reset     (i_reset),
    .i_spi_csel  (i_spi_csel),
    .i_spi_clk   (i_spi_clk),
    .i_spi_mosi  (i_spi_mosi),
    .i_tx_byte   (w_tx_byte),
    .o_spi_miso  (o_spi_miso),
    .o_cs_active (w_cs_active),
    .o_cs_fall   (w_cs_fall),
    .o_cs_rise   (w_cs_rise),
    .o_sclk_rise (w_sclk_rise),
    .o_byte_done (w_byte_done),
    .o_rx_byte   (w_rx_byte),
    .o_load      (w_load)
  );

  assign o_mem_addr  = r_addr;
  assign o_mem_re    = r_mem_re;
  assign o_mem_we    = r_mem_we;
  assign o_mem_wdata = r_wdata;
  assign o_erase_req = r_erase_req;
  assign o_wip       = r_wip;

  always_comb begin
    w_status         = 8'd0;
    w_status[SR_WIP] = r_wip;
    w_status[SR_WEL] = r_wel;
  end

  // Response byte; taken by the shifter on the fall after each byte boundary,
  // so RDSR status is re-captured per byte.
  always_comb begin
    w_tx_byte = 8'h00;
    case (r_state)
      ST_RDID: begin
        case (r_out_idx)
          2'd0:    w_tx_byte = JEDEC_ID[23:16];
          2'd1:    w_tx_byte = JEDEC_ID[15:8];
          2'd2:    w_tx_byte = JEDEC_ID[7:0];
          default: w_tx_byte = 8'hFF;
        endcase
      end
      ST_RDSR: w_tx_byte = w_status;
      ST_READ: w_tx_byte = r_rdata;
      default: w_tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_kind_next   = r_kind;
    w_wel_op_next = r_wel_op;
    w_re_set      = 1'b0;
    w_we_set      = 1'b0;
    w_erase_set   = 1'b0;
    w_busy_start  = 1'b0;
    if (!w_cs_active) begin
      w_state_next  = ST_IDLE;
      w_wel_op_next = WEL_KEEP;
      // CS rise commits PP/SE; a partial PP byte never produced a write.
      if (w_cs_rise) begin
        if (r_state == ST_PROG && r_prog_wrote) begin
          w_busy_start = 1'b1;
        end
        if (r_state == ST_ERASE_WAIT && r_wel) begin
          w_erase_set  = 1'b1;
          w_busy_start = 1'b1;
        end
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) w_state_next = ST_CMD;
        end
        ST_CMD: begin
          if (w_byte_done) begin
            if (r_wip && w_rx_byte != CMD_RDSR) begin
              w_state_next = ST_IGNORE;
            end else begin
              case (w_rx_byte)
                CMD_RDID: w_state_next = ST_RDID;
                CMD_RDSR: w_state_next = ST_RDSR;
                CMD_WREN: begin
                  w_state_next  = ST_IGNORE;
                  w_wel_op_next = WEL_SET;
                end
                CMD_WRDI: begin
                  w_state_next  = ST_IGNORE;
                  w_wel_op_next = WEL_CLR;
                end
                CMD_READ: begin
                  w_state_next = ST_ADDR;
                  w_kind_next  = KIND_READ;
                end
                CMD_PP: begin
                  w_state_next = r_wel ? ST_ADDR : ST_IGNORE;
                  w_kind_next  = KIND_PROG;
                end
                CMD_SE: begin
                  w_state_next = ST_ADDR;
                  w_kind_next  = KIND_ERASE;
                end
                default: w_state_next = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (w_byte_done && r_addr_cnt == 2'd2) begin
            case (r_kind)
              KIND_READ: begin
                w_state_next = ST_READ;
                w_re_set     = 1'b1;
              end
              KIND_PROG: w_state_next = ST_PROG;
              default:   w_state_next = ST_ERASE_WAIT;
            endcase
          end
        end
        ST_READ: begin
          if (w_byte_done) w_re_set = 1'b1;
        end
        ST_PROG: begin
          if (w_byte_done) w_we_set = 1'b1;
        end
        ST_ERASE_WAIT: begin
          // Any bit beyond the 24 address bits invalidates the erase.
          if (w_sclk_rise) w_state_next = ST_IGNORE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk_48mhz) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_kind       <= KIND_READ;
      r_wel_op     <= WEL_KEEP;
      r_wel        <= 1'b0;
      r_wip        <= 1'b0;
      r_busy_cnt   <= '0;
      r_addr       <= '0;
      r_addr_cnt   <= 2'd0;
      r_out_idx    <= 2'd0;
      r_prog_wrote <= 1'b0;
      r_rdata      <= 8'd0;
      r_mem_re     <= 1'b0;
      r_re_pend    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_wdata      <= 8'd0;
      r_erase_req  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_kind      <= w_kind_next;
      r_wel_op    <= w_wel_op_next;
      r_mem_re    <= w_re_set;
      r_re_pend   <= r_mem_re;
      r_mem_we    <= w_we_set;
      r_erase_req <= w_erase_set;

      if (w_cs_fall) begin
        r_addr_cnt   <= 2'd0;
        r_out_idx    <= 2'd0;
        r_prog_wrote <= 1'b0;
      end

      if (r_state == ST_ADDR && w_byte_done) begin
        r_addr     <= {r_addr[ADDR_W-9:0], w_rx_byte};
        r_addr_cnt <= r_addr_cnt + 2'd1;
      end

      // Read data arrives the cycle after the strobe; advance past it then.
      if (r_re_pend) begin
        r_rdata <= i_mem_rdata;
        r_addr  <= r_addr + ADDR_W'(1);
      end

      // Programming stays inside the page: only the low bits advance.
      if (r_mem_we) begin
        r_addr[PAGE_W-1:0] <= r_addr[PAGE_W-1:0] + PAGE_W'(1);
      end

      if (w_we_set) begin
        r_wdata      <= w_rx_byte;
        r_prog_wrote <= 1'b1;
      end

      if (w_load && r_state == ST_RDID && r_out_idx != 2'd3) begin
        r_out_idx <= r_out_idx + 2'd1;
      end

      if (w_cs_rise) begin
        case (r_wel_op)
          WEL_SET: r_wel <= 1'b1;
          WEL_CLR: r_wel <= 1'b0;
          default: ;
        endcase
      end

      if (w_busy_start) begin
        r_wip      <= 1'b1;
        r_wel      <= 1'b0;
        r_busy_cnt <= BUSY_W'(BUSY_CYCLES);
      end else if (r_wip) begin
        r_busy_cnt <= r_busy_cnt - BUSY_W'(1);
        if (r_busy_cnt == BUSY_W'(1)) r_wip <= 1'b0;
      end
    end
  end

endmodule
